// File: rtl/ram_fill_ctrl.sv
// Line-refill controller owning cache RAM port 0: issues one burst read per fill
// and writes returned beats into the line slot, forwarding core reads while idle.
module ram_fill_ctrl #(
    parameter int unsigned DBITS      = 64,
    parameter int unsigned ABITS      = 9,
    parameter int unsigned BEATS_LOG2 = 2,
    parameter int unsigned MABITS     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        fill_req_valid,
    output logic                        fill_req_ready,
    input  logic [MABITS-1:0]           fill_req_addr,
    input  logic [ABITS-BEATS_LOG2-1:0] fill_req_index,

    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [MABITS-1:0]           mem_req_addr,
    output logic [7:0]                  mem_req_len,

    input  logic                        mem_resp_valid,
    output logic                        mem_resp_ready,
    input  logic [DBITS-1:0]            mem_resp_data,
    input  logic                        mem_resp_last,

    input  logic [ABITS-1:0]            cpu_addr,
    input  logic                        cpu_re,
    output logic                        cpu_stall,

    output logic [ABITS-1:0]            ram_addr0,
    output logic                        ram_re0,
    output logic [DBITS-1:0]            ram_wr0,
    output logic                        ram_we0,

    output logic                        fill_done,
    output logic                        fill_err
);

    localparam int unsigned BEATS = 1 << BEATS_LOG2;
    localparam int unsigned IBITS = ABITS - BEATS_LOG2;
    localparam logic [BEATS_LOG2-1:0] LastBeat = '1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill
    } state_e;

    state_e                  state_q, state_d;
    logic [BEATS_LOG2-1:0]   beat_q, beat_d;
    logic [MABITS-1:0]       addr_q, addr_d;
    logic [IBITS-1:0]        index_q, index_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    done_err_q, done_err_d;

    logic                    beat_accept;
    logic                    last_mismatch;

    assign beat_accept   = (state_q == StFill) && mem_resp_valid;
    assign last_mismatch = mem_resp_last != (beat_q == LastBeat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            addr_q     <= '0;
            index_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            index_q    <= index_d;
            err_q      <= err_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        index_d    = index_q;
        err_d      = err_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fill_req_valid) begin
                    addr_d  = fill_req_addr;
                    index_d = fill_req_index;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (beat_accept) begin
                    beat_d = beat_q + 1'b1;
                    if (last_mismatch) begin
                        err_d = 1'b1;
                    end
                    // Termination is by beat count alone; mem_resp_last only feeds the error flag.
                    if (beat_q == LastBeat) begin
                        done_d     = 1'b1;
                        done_err_d = err_q | last_mismatch;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fill_req_ready = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        cpu_stall      = 1'b1;
        ram_re0        = 1'b0;
        ram_we0        = 1'b0;
        ram_addr0      = {index_q, beat_q};

        unique case (state_q)
            StIdle: begin
                fill_req_ready = 1'b1;
                cpu_stall      = 1'b0;
                ram_re0        = cpu_re;
                ram_addr0      = cpu_addr;
            end
            StReq: begin
                mem_req_valid = 1'b1;
            end
            StFill: begin
                mem_resp_ready = 1'b1;
                ram_we0        = mem_resp_valid;
            end
            default: ;
        endcase
    end

    assign mem_req_addr = addr_q;
    assign mem_req_len  = 8'(BEATS - 1);
    assign ram_wr0      = mem_resp_data;
    assign fill_done    = done_q;
    assign fill_err     = done_err_q;

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// Directed bench for ram_fill_ctrl: reset/idle forwarding, normal and gapped fills,
// last-marker error, mid-fill reset and same-cycle core read with fill accept.
module tb_ram_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_req_valid, fill_req_ready;
    logic [31:0] fill_req_addr;
    logic [6:0]  fill_req_index;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic        mem_resp_valid, mem_resp_ready, mem_resp_last;
    logic [63:0] mem_resp_data;
    logic [8:0]  cpu_addr;
    logic        cpu_re, cpu_stall;
    logic [8:0]  ram_addr0;
    logic        ram_re0, ram_we0;
    logic [63:0] ram_wr0;
    logic        fill_done, fill_err;

    int n_cmp = 0;
    int n_err = 0;

    ram_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_addr  (fill_req_addr),
        .fill_req_index (fill_req_index),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_len    (mem_req_len),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_last  (mem_resp_last),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_stall      (cpu_stall),
        .ram_addr0      (ram_addr0),
        .ram_re0        (ram_re0),
        .ram_wr0        (ram_wr0),
        .ram_we0        (ram_we0),
        .fill_done      (fill_done),
        .fill_err       (fill_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fill: accept, 2-cycle delayed mem_req_ready, 4 beats with optional gaps.
    task automatic do_fill(input logic [6:0] idx, input logic [31:0] addr, input int gap,
                           input int last_at, input logic exp_err, input logic cpu_rd,
                           input logic [63:0] seed);
        fill_req_valid = 1'b1;
        fill_req_addr  = addr;
        fill_req_index = idx;
        cpu_re         = cpu_rd;
        cpu_addr       = 9'h1AB;
        mem_req_ready  = 1'b0;
        #1;
        chk("accept_ready", fill_req_ready, 1);
        chk("accept_stall", cpu_stall, 0);
        if (cpu_rd) begin
            chk("fwd_re0", ram_re0, 1);
            chk("fwd_addr0", ram_addr0, 64'h1AB);
            chk("fwd_we0", ram_we0, 0);
        end
        tick();
        fill_req_valid = 1'b0;
        cpu_re         = 1'b1;
        #1;
        chk("req_stall", cpu_stall, 1);
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, {32'h0, addr});
        chk("req_len", mem_req_len, 3);
        chk("req_re0", ram_re0, 0);
        chk("req_ready_lo", fill_req_ready, 0);
        repeat (2) begin
            tick();
            chk("req_hold", mem_req_valid, 1);
            chk("req_no_resp", mem_resp_ready, 0);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("fill_req_drop", mem_req_valid, 0);
        chk("fill_resp_ready", mem_resp_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    mem_resp_valid = 1'b0;
                    #1;
                    chk("gap_we0", ram_we0, 0);
                    chk("gap_stall", cpu_stall, 1);
                    chk("gap_resp_ready", mem_resp_ready, 1);
                    tick();
                end
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = seed + 64'(i);
            mem_resp_last  = (i == last_at);
            #1;
            chk("beat_we0", ram_we0, 1);
            chk("beat_addr0", ram_addr0, 64'(idx) * 4 + 64'(i));
            chk("beat_wr0", ram_wr0, seed + 64'(i));
            chk("beat_re0", ram_re0, 0);
            chk("beat_no_done", fill_done, 0);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_last  = 1'b0;
        #1;
        chk("done_pulse", fill_done, 1);
        chk("done_err", fill_err, exp_err);
        chk("done_ready", fill_req_ready, 1);
        chk("done_resp_ready", mem_resp_ready, 0);
        chk("done_stall", cpu_stall, 0);
        tick();
        chk("done_clear", fill_done, 0);
        chk("err_clear", fill_err, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        fill_req_valid = 1'b0;
        fill_req_addr  = '0;
        fill_req_index = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_last  = 1'b0;
        cpu_re         = 1'b1;
        cpu_addr       = 9'h005;
        #1;

        // Reset then idle forwarding
        chk("rst_re0", ram_re0, 1);
        chk("rst_addr0", ram_addr0, 64'h005);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_resp_ready", mem_resp_ready, 0);
        chk("rst_we0", ram_we0, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_err", fill_err, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_ready", fill_req_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_re0", ram_re0, 1);
        chk("idle_addr0", ram_addr0, 64'h005);

        // Back-to-back beats, correct last
        do_fill(7'd3, 32'h8000_0040, 0, 3, 1'b0, 1'b0, 64'hD000_0000_0000_0000);
        // Gapped beats
        do_fill(7'd3, 32'h8000_0040, 2, 3, 1'b0, 1'b0, 64'hD100_0000_0000_00A0);
        // Last on beat 1: still 4 writes, error flagged
        do_fill(7'd3, 32'h8000_0040, 0, 1, 1'b1, 1'b0, 64'hE000_0000_0000_0010);

        // Reset mid-fill after three beats
        fill_req_valid = 1'b1;
        fill_req_addr  = 32'h1234_5600;
        fill_req_index = 7'd21;
        tick();
        fill_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'hAA00 + 64'(i);
            mem_resp_last  = 1'b0;
            tick();
        end
        chk("mid_resp_ready", mem_resp_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", fill_req_ready, 1);
        chk("mid_rst_we0", ram_we0, 0);
        chk("mid_rst_resp_ready", mem_resp_ready, 0);
        chk("mid_rst_stall", cpu_stall, 0);
        chk("mid_rst_req_addr", mem_req_addr, 0);
        tick();
        chk("mid_rst_no_done", fill_done, 0);
        mem_resp_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_done", fill_done, 0);
        do_fill(7'd21, 32'h1234_5600, 1, 3, 1'b0, 1'b0, 64'h5555_0000_0000_0000);

        // Core read in the accepting IDLE cycle
        do_fill(7'd127, 32'hFFFF_FFE0, 0, 3, 1'b0, 1'b1, 64'h0123_4567_89AB_CDE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_fill_ctrl.md
# ram_fill_ctrl

Line-refill controller that sits directly upstream of the dual-port cache RAM and owns its read/write port (port 0). It accepts a line-fill request, issues one burst read to the memory bus, and writes each returned beat into the RAM line slot. It multiplexes the core's port-0 reads onto the RAM when idle and stalls them while a fill is in progress. The RAM's read-only port (port 1) is not touched by this block.

## Interface

- DBITS, 64, RAM word and memory beat width
- ABITS, 9, RAM address width (words)
- BEATS_LOG2, 2, log2 of beats per line; BEATS = 1 << BEATS_LOG2; line slots = 1 << (ABITS-BEATS_LOG2)
- MABITS, 32, memory byte-address width

Ports:

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- fill_req_valid  in  1  fill request
- fill_req_ready  out  1  high only in IDLE
- fill_req_addr  in  MABITS  line-aligned memory byte address
- fill_req_index  in  ABITS-BEATS_LOG2  destination line slot
- mem_req_valid  out  1  burst request valid
- mem_req_ready  in  1  burst request accepted
- mem_req_addr  out  MABITS  registered copy of fill_req_addr
- mem_req_len  out  8  constant BEATS-1
- mem_resp_valid  in  1  beat valid
- mem_resp_ready  out  1  high only in FILL
- mem_resp_data  in  DBITS  beat data
- mem_resp_last  in  1  final-beat marker
- cpu_addr  in  ABITS  core port-0 read address
- cpu_re  in  1  core port-0 read enable
- cpu_stall  out  1  core must hold cpu_re/cpu_addr
- ram_addr0  out  ABITS  to RAM addr0
- ram_re0  out  1  to RAM re0
- ram_wr0  out  DBITS  to RAM wr0
- ram_we0  out  1  to RAM we0
- fill_done  out  1  one-cycle pulse, fill complete
- fill_err  out  1  one-cycle pulse with fill_done, last-marker mismatch

## Operation

- States: IDLE, REQ, FILL.
- IDLE: fill_req_ready=1, cpu_stall=0; ram_re0=cpu_re, ram_addr0=cpu_addr, ram_we0=0. On fill_req_valid: latch addr and index, clear beat counter and error flag, go REQ.
- REQ: mem_req_valid=1 with stable addr/len; on mem_req_ready go FILL.
- FILL: mem_resp_ready=1. Each cycle mem_resp_valid=1: ram_we0=1, ram_addr0={index, beat}, ram_wr0=mem_resp_data (combinational pass-through), beat increments. ram_re0 forced 0 in REQ and FILL (RAM read preempts write on port 0).
- Error: mem_resp_last != (beat==BEATS-1) on any accepted beat sets error flag.
- Completion on the accepted beat with beat==BEATS-1 (counter only, last ignored for termination): go IDLE; fill_done=1 next cycle, fill_err=flag.
- cpu_stall=1 in REQ and FILL. Core read presented in the same IDLE cycle as an accepted fill request is forwarded to the RAM (no write occurs until FILL).
- Beats after termination are not accepted (mem_resp_ready=0).

## Timing

- Reset values: state IDLE, beat 0, mem_req_valid 0, mem_resp_ready 0, ram_we0 0, ram_re0 follows cpu_re, fill_done 0, fill_err 0, cpu_stall 0, mem_req_addr 0.
- Reset mid-fill: immediate return to IDLE, partial line left in RAM, no fill_done; memory side must be reset together.
- Request to mem_req_valid: 1 cycle. mem_req_valid held until handshake.
- Beat to RAM write: 0 cycles (same edge). Final beat to fill_done: 1 cycle. Back-to-back fills: new request accepted the cycle fill_done pulses.
- Minimum fill: 1 (REQ) + BEATS cycles after acceptance.
- Beat counter BEATS_LOG2 bits, wraps to 0 on completion.

## Test plan

- Reset then idle: cpu_re=1, cpu_addr=0x05 -> ram_re0=1, ram_addr0=0x05, cpu_stall=0, all fill outputs 0.
- Fill index 3, addr 0x8000_0040, mem_req_ready delayed 2 cycles, 4 back-to-back beats D0..D3 with last on D3 -> writes to 0x0C..0x0F, fill_done one cycle after D3, fill_err=0.
- Same fill with mem_resp_valid gaps between every beat -> identical writes, ram_we0 only on valid cycles, cpu_stall held throughout.
- last asserted on beat 1 -> all 4 beats still written, fill_done and fill_err both pulse after beat 3.
- rst_n pulled low after beat 2 -> state IDLE asynchronously, ram_we0=0, no fill_done; next fill completes normally.
- cpu_re=1 with fill_req_valid in same IDLE cycle -> read forwarded that cycle, fill accepted, cpu_stall=1 next cycle.
